// File: rtl/uart_pkg.sv
// Shared constants for the UART frame transmitter: state encodings, parity modes
// and the baud divider.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int baud_div(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Host-side bundle of the frame transmitter: payload and request in, status and
// serial line out.
interface uart_frame_tx_if #(
  parameter int PAYLOAD_BYTES = 3
);
  logic [8*PAYLOAD_BYTES-1:0] payload_data;
  logic                       send_req;
  logic                       busy;
  logic                       frame_done;
  logic                       tx;

  modport master (output payload_data, send_req, input  busy, frame_done, tx);
  modport slave  (input  payload_data, send_req, output busy, frame_done, tx);
endinterface

// File: rtl/uart_byte_tx.sv
// One-byte UART serialiser. Accepting a new byte in the last stop-bit cycle lets
// bytes run back to back with no idle gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int BIT_CYC    = 10,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int   CW       = $clog2(BIT_CYC);
  localparam logic PAR_INIT = PARITY_ODD ? PAR_ODD : PAR_EVEN;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_q == CW'(BIT_CYC - 1));
  assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
  assign tx_o    = tx_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    baud_d  = ((state_q == ST_IDLE) || bit_end) ? '0 : baud_q + CW'(1);
    if (ready_o && valid_i) begin
      state_d = ST_START;
      tx_d    = 1'b0;
      sh_d    = data_i;
      par_d   = (^data_i) ^ PAR_INIT;
      bit_d   = '0;
    end else if (bit_end) begin
      case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          tx_d    = sh_q[0];
        end
        ST_DATA: begin
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Telemetry framer: header, snapshotted payload and optional checksum sent as one
// UART burst on a timer tick and/or explicit request.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int         UART_BPS      = 115200,
  parameter int         CLK_FREQ      = 50_000_000,
  parameter int         PAYLOAD_BYTES = 3,
  parameter logic [7:0] HEADER        = 8'hA5,
  parameter bit         CHECKSUM_EN   = 1'b1,
  parameter bit         PARITY_EN     = 1'b0,
  parameter bit         PARITY_ODD    = 1'b0,
  parameter int         PERIOD_MS     = 1000
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  uart_frame_tx_if.slave bus
);
  localparam int BIT_CYC    = baud_div(CLK_FREQ, UART_BPS);
  localparam int PERIOD_CYC = (CLK_FREQ / 1000) * PERIOD_MS;
  localparam int NBYTES     = PAYLOAD_BYTES + 1 + int'(CHECKSUM_EN);
  localparam int IW         = $clog2(NBYTES + 1);

  if (BIT_CYC < 4) begin : g_chk_baud
    $error("uart_frame_tx: BIT_CYC below 4");
  end
  if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 16) begin : g_chk_len
    $error("uart_frame_tx: PAYLOAD_BYTES out of range 1..16");
  end

  logic tick;

  if (PERIOD_MS > 0) begin : g_timer
    localparam int TW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    logic [TW-1:0] tmr_q;
    assign tick = (tmr_q == TW'(PERIOD_CYC - 1));
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) tmr_q <= '0;
      else if (tick)  tmr_q <= '0;
      else            tmr_q <= tmr_q + TW'(1);
    end
  end else begin : g_no_timer
    assign tick = 1'b0;
  end

  logic [2:0]                 state_q, state_d;
  logic                       pend_q, pend_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [8*PAYLOAD_BYTES-1:0] snap_q, snap_d;
  logic [7:0]                 csum_q, csum_d;
  logic                       done_q, done_d;
  logic                       busy_q;
  logic [7:0]                 csum_sum;
  logic [7:0]                 byte_dat;
  logic                       byte_vld, byte_rdy, byte_tx;
  logic                       trig;

  assign trig = tick | bus.send_req;

  always_comb begin
    csum_sum = HEADER;
    for (int i = 0; i < PAYLOAD_BYTES; i++)
      csum_sum = csum_sum + bus.payload_data[8*i +: 8];
  end

  // idx_q is the wire position of the byte being offered to the byte engine
  always_comb begin
    byte_dat = HEADER;
    for (int i = 0; i < PAYLOAD_BYTES; i++)
      if (idx_q == IW'(i + 1)) byte_dat = snap_q[8*i +: 8];
    if (idx_q == IW'(PAYLOAD_BYTES + 1)) byte_dat = csum_q;
  end

  // The framer parks in ST_DATA while the byte engine walks START..STOP
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    csum_d   = csum_q;
    done_d   = 1'b0;
    byte_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig || pend_q) begin
          state_d = ST_LOAD;
          pend_d  = 1'b0;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (trig) pend_d = 1'b1;
        byte_vld = 1'b1;
        snap_d   = bus.payload_data;
        csum_d   = csum_sum;
        idx_d    = IW'(1);
        state_d  = ST_DATA;
      end
      default: begin
        if (trig) pend_d = 1'b1;
        byte_vld = (idx_q < IW'(NBYTES));
        if (byte_rdy) begin
          if (byte_vld) begin
            idx_d = idx_q + IW'(1);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      snap_q  <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  uart_byte_tx #(
    .BIT_CYC    (BIT_CYC),
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD)
  ) u_byte (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .data_i  (byte_dat),
    .valid_i (byte_vld),
    .ready_o (byte_rdy),
    .tx_o    (byte_tx)
  );

  assign bus.tx         = byte_tx;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART telemetry framer and transmitter. It packs an N-byte payload into a framed packet: header byte, payload bytes, then an optional checksum byte. Each byte goes out as 8N1, or 8E1/8O1 when parity is enabled. A frame starts on a periodic timer tick, on an explicit request, or both. It replaces the fixed 3-byte, 1 s status sender at the board's debug UART pin. Payload is snapshotted at frame start, so a frame never mixes old and new data.

## Interface
- UART_BPS, 115200, line baud rate
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz
- PAYLOAD_BYTES, 3, payload byte count, legal range 1..16
- HEADER, 8'hA5, sync byte sent first in every frame
- CHECKSUM_EN, 1, 1 = append checksum byte: sum mod 256 of header and all payload bytes
- PARITY_EN, 0, 1 = insert a parity bit after D7
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
- PERIOD_MS, 1000, auto-send period in ms; 0 = request-only mode
- sys_clk  in  1  system clock; the only clock
- sys_rst_n  in  1  asynchronous, active-low reset
- payload_data  in  8*PAYLOAD_BYTES  payload; byte i = payload_data[8i+7:8i]
- send_req  in  1  one-cycle request to send a frame
- busy  out  1  high from LOAD through the end of the last stop bit
- frame_done  out  1  one-cycle pulse after the last stop bit completes
- tx  out  1  serial line, registered, idles high

## Operation
- Derived constants:
  - BIT_CYC = CLK_FREQ/UART_BPS, integer-truncated; elaboration error if below 4.
  - PERIOD_CYC = (CLK_FREQ/1000)*PERIOD_MS.
  - NBYTES = PAYLOAD_BYTES + 1 + CHECKSUM_EN.
- Byte order on the wire: HEADER, payload byte 0, 1, …, PAYLOAD_BYTES-1, then checksum if enabled.
- Bit order within a byte: start (0), D0..D7 LSB first, parity if enabled, stop (1).
- Period timer:
  - Counts 0..PERIOD_CYC-1 continuously from reset and emits a tick on wrap.
  - Disabled entirely when PERIOD_MS = 0.
- Trigger and pending request:
  - Trigger = tick OR send_req.
  - A trigger arriving in any state other than IDLE sets a single `pending` flag. Multiple triggers collapse into one.
  - In IDLE, a trigger or pending starts a frame and clears pending.
- State machine:
  - IDLE: tx = 1. On trigger or pending, go to LOAD.
  - LOAD (1 cycle): snapshot payload_data, compute checksum, byte index = 0. Go to START.
  - START: tx = 0 for BIT_CYC cycles. Go to DATA.
  - DATA: 8 bits of BIT_CYC cycles each. Go to PARITY if PARITY_EN, otherwise STOP.
  - PARITY: tx = XOR of the data bits, XOR PARITY_ODD, for BIT_CYC cycles. Go to STOP.
  - STOP: tx = 1 for BIT_CYC cycles.
    - If byte index < NBYTES-1: increment the index and go to START.
    - Otherwise: pulse frame_done and go to IDLE.
- The checksum is computed in LOAD from the snapshot, not from live inputs.

## Timing
- Reset values: tx = 1, busy = 0, frame_done = 0, state = IDLE, pending = 0, timer = 0, baud counter = 0.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). No partial frame resumes.
- Start latency: a trigger sampled at edge k puts the FSM in LOAD and sets busy at k+1. tx falls at edge k+2.
- Bit length: every bit lasts exactly BIT_CYC cycles. Bytes follow back to back with no idle gap between them.
- Frame length = NBYTES*(10+PARITY_EN)*BIT_CYC cycles, measured from tx falling to the end of the last stop bit.
- End of frame: frame_done is high for one cycle, concurrent with the FSM returning to IDLE. busy falls on that same edge.
- Back-to-back frames: with pending set, the next LOAD follows the IDLE cycle. The idle gap is therefore exactly 2 cycles at tx = 1 before the next start bit.
- Tick and send_req in the same cycle count as one trigger.
- The timer is not resynchronised by send_req.

## Structure
- Package uart_pkg holds:
  - FSM state enum (IDLE, LOAD, START, DATA, PARITY, STOP);
  - function for the baud divider;
  - parity-mode constants.
- Sub-module uart_byte_tx:
  - Handshake: byte + valid/ready in, tx out.
  - Owns the baud counter, bit counter and parity generation.
- The framer owns the timer, pending flag, snapshot register, checksum and byte index.

## Test plan
- Sim parameters, unless overridden below: CLK_FREQ = 1_000_000, UART_BPS = 100_000 (BIT_CYC = 10), PERIOD_MS = 0, payload 24'h123456.
- Basic frame: send_req pulse -> tx falls 2 cycles later. Decoded bytes are A5, 56, 34, 12, 41. frame_done pulses 500 cycles after tx falls.
- Parity: PARITY_EN = 1 with PARITY_ODD = 0 -> header parity bit 0 and frame length 550 cycles. With PARITY_ODD = 1 -> header parity bit 1.
- Periodic send: PERIOD_MS = 1 -> a frame starts every 1000 cycles. Verify three frames in a row, and that changing payload_data mid-frame leaves that frame's bytes unchanged.
- Collision: send_req pulsed 3 times during a frame -> exactly one extra frame, starting with a 2-cycle gap after frame_done.
- Mid-frame reset: assert sys_rst_n low during payload byte 1 -> tx = 1 and busy = 0 at once. After release there is no output until the next trigger.
- Checksum disabled (CHECKSUM_EN = 0, PAYLOAD_BYTES = 1, payload 8'hFF) -> bytes A5, FF only. Frame length 200 cycles.
